seg_counter_mux_ctrl: RTL and testbench

- Parametrised successor to the single-digit prescaled seven-segment counter controller.
- Counts across NUM_DIGITS digits, decimal or hex, up or down, with synchronous clear.
- Time-multiplexes the digits onto one shared 7-segment bus plus a one-hot digit-select bus.
- Sits directly behind the chip IO wrapper: clk and reset come from io_in, segment and digit lines go to io_out.

---
 rtl/seg_ctrl_pkg.sv | 44 ++++
 rtl/seg7_decoder.sv | 41 ++++
 rtl/seg_counter_mux_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_seg_counter_mux_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_ctrl_pkg
// Description : Shared constants for the multi-digit seven-segment counter.
//               Holds the active-high glyphs (bit0 = a ... bit6 = g), the
//               number-base constants and a width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_ctrl_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam int BASE_DEC = 10;
  localparam int BASE_HEX = 16;

  // Bits needed to hold 0..value-1. Never returns less than 1 so that a
  // counter with a single legal state still gets a real (constant) register.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seg7_decoder
// Description : Combinational 4-bit value to 7-segment glyph lookup,
//               covering 0-9 and A, b, C, d, E, F.
// Ports       : val_i [3:0]  digit value
//               seg_o [6:0]  active-high segments, bit0 = a ... bit6 = g
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_decoder
  import seg_ctrl_pkg::*;
(
  input  logic [3:0] val_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (val_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seg_counter_mux_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg_counter_mux_ctrl
// Description : Prescaled NUM_DIGITS-digit decimal/hex up/down counter whose
//               digits are time-multiplexed onto one 7-segment bus.
// Ports       : clk        system clock
//               rst        synchronous active-low reset
//               en         prescaler / count enable
//               up         1 = count up, 0 = count down
//               hex_mode   1 = base 16, 0 = base 10
//               clear      synchronous clear of count and prescaler
//               segments   registered active-high segments (bit0 = a)
//               digit_sel  registered one-hot digit enable
//               tick       one-cycle pulse per count step
//               wrap       one-cycle pulse when the count wraps
// Options     : define LEADING_ZERO_BLANK_EN to blank leading zero digits
//               (digit 0 is never blanked).
// Revision    : 1.0 - initial release
// ============================================================================
module seg_counter_mux_ctrl
  import seg_ctrl_pkg::*;
#(
  parameter int MAX_COUNT     = 10_000_000,
  parameter int NUM_DIGITS    = 2,
  parameter int REFRESH_COUNT = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  hex_mode,
  input  logic                  clear,
  output logic [6:0]            segments,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic                  tick,
  output logic                  wrap
);

  localparam int PW = clog2(MAX_COUNT);
  localparam int IW = clog2(NUM_DIGITS);
  localparam int RW = clog2(REFRESH_COUNT);

  localparam logic [PW-1:0] c_presc_last = PW'(MAX_COUNT - 1);
  localparam logic [IW-1:0] c_idx_last   = IW'(NUM_DIGITS - 1);
  localparam logic [RW-1:0] c_refr_last  = RW'(REFRESH_COUNT - 1);

  // State
  logic [PW-1:0]                presc_q, presc_d;
  logic [NUM_DIGITS-1:0][3:0]   digits_q, digits_d;
  logic [IW-1:0]                idx_q, idx_d;
  logic [RW-1:0]                refr_q, refr_d;
  logic                         hex_q;
  logic [6:0]                   segments_q, segments_d;
  logic [NUM_DIGITS-1:0]        digit_sel_q, digit_sel_d;
  logic                         tick_q, tick_d;
  logic                         wrap_q, wrap_d;

  // Combinational helpers
  logic                         w_presc_last;
  logic                         w_hex_fall;
  logic [3:0]                   w_digit_last;
  logic [NUM_DIGITS-1:0][3:0]   w_stepped;
  logic                         w_carry;
  logic [3:0]                   w_sel_digit;
  logic [6:0]                   w_dec_seg;
  logic                         w_blank;

  assign w_presc_last = (presc_q == c_presc_last);
  // hex_q tracks hex_mode every cycle so a 1->0 transition is seen on the
  // very next edge, independent of the tick timing.
  assign w_hex_fall   = hex_q & ~hex_mode;

  // --------------------------------------------------------------------------
  // Ripple step: the carry/borrow enters digit 0 and propagates while each
  // digit rolls over. A carry still set past the top digit means the whole
  // count wrapped.
  // --------------------------------------------------------------------------
  always_comb begin
    w_digit_last = hex_mode ? 4'(BASE_HEX - 1) : 4'(BASE_DEC - 1);
    w_carry      = 1'b1;
    w_stepped    = digits_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_carry) begin
        if (up) begin
          if (digits_q[i] == w_digit_last) begin
            w_stepped[i] = 4'd0;
          end else begin
            w_stepped[i] = digits_q[i] + 4'd1;
            w_carry      = 1'b0;
          end
        end else begin
          if (digits_q[i] == 4'd0) begin
            w_stepped[i] = w_digit_last;
          end else begin
            w_stepped[i] = digits_q[i] - 4'd1;
            w_carry      = 1'b0;
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Prescaler and digit next-state. Clear outranks everything; a hex->dec
  // transition clamps out-of-range digits and swallows that cycle's step
  // (the prescaler itself keeps running).
  // --------------------------------------------------------------------------
  always_comb begin
    presc_d  = presc_q;
    digits_d = digits_q;
    tick_d   = 1'b0;
    wrap_d   = 1'b0;
    if (clear) begin
      presc_d  = '0;
      digits_d = '0;
    end else begin
      if (en) begin
        presc_d = w_presc_last ? '0 : presc_q + PW'(1);
      end
      if (w_hex_fall) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (digits_q[i] > 4'd9) digits_d[i] = 4'd0;
        end
      end else if (en && w_presc_last) begin
        digits_d = w_stepped;
        tick_d   = 1'b1;
        wrap_d   = w_carry;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Display mux: free-running refresh counter selects the digit shown.
  // --------------------------------------------------------------------------
  always_comb begin
    refr_d = (refr_q == c_refr_last) ? '0 : refr_q + RW'(1);
    idx_d  = idx_q;
    if (refr_q == c_refr_last) begin
      idx_d = (idx_q == c_idx_last) ? '0 : idx_q + IW'(1);
    end
  end

  always_comb begin
    w_sel_digit = 4'd0;
    digit_sel_d = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        w_sel_digit    = digits_q[i];
        digit_sel_d[i] = 1'b1;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Blank the shown digit when it and everything above it are zero.
  always_comb begin
    w_blank = 1'b0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        w_blank = 1'b1;
        for (int j = i; j < NUM_DIGITS; j++) begin
          if (digits_q[j] != 4'd0) w_blank = 1'b0;
        end
      end
    end
  end
`else
  assign w_blank = 1'b0;
`endif

  seg7_decoder u_seg7_decoder (
    .val_i (w_sel_digit),
    .seg_o (w_dec_seg)
  );

  assign segments_d = w_blank ? SEG_BLANK : w_dec_seg;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      presc_q     <= '0;
      digits_q    <= '0;
      idx_q       <= '0;
      refr_q      <= '0;
      hex_q       <= 1'b0;
      segments_q  <= SEG_0;
      digit_sel_q <= NUM_DIGITS'(1);
      tick_q      <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      digits_q    <= digits_d;
      idx_q       <= idx_d;
      refr_q      <= refr_d;
      hex_q       <= hex_mode;
      segments_q  <= segments_d;
      digit_sel_q <= digit_sel_d;
      tick_q      <= tick_d;
      wrap_q      <= wrap_d;
    end
  end

  assign segments  = segments_q;
  assign digit_sel = digit_sel_q;
  assign tick      = tick_q;
  assign wrap      = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_counter_mux_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_counter_mux_ctrl
// Description : Self-checking bench for seg_counter_mux_ctrl with
//               MAX_COUNT=4, REFRESH_COUNT=2, NUM_DIGITS=2. The reference
//               model holds the count as digit values advanced by whole-number
//               arithmetic in the current base. Honours LEADING_ZERO_BLANK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_counter_mux_ctrl;

  localparam int MAXC = 4;
  localparam int REFC = 2;
  localparam int ND   = 2;

  logic          clk = 1'b0;
  logic          rst, en, up, hex_mode, clear;
  logic [6:0]    segments;
  logic [ND-1:0] digit_sel;
  logic          tick, wrap;

  always #5 clk = ~clk;

  seg_counter_mux_ctrl #(
    .MAX_COUNT     (MAXC),
    .NUM_DIGITS    (ND),
    .REFRESH_COUNT (REFC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .up        (up),
    .hex_mode  (hex_mode),
    .clear     (clear),
    .segments  (segments),
    .digit_sel (digit_sel),
    .tick      (tick),
    .wrap      (wrap)
  );

  int    n_chk = 0;
  int    n_err = 0;
  string phase = "init";

  // Reference model state
  int         m_dig [ND];
  int         m_pre;
  int         m_cyc;
  bit         m_prev_hex;
  logic [6:0] e_seg;
  logic [ND-1:0] e_sel;
  logic       e_tick, e_wrap;
  int         dut_wraps;
  logic [6:0] glyph [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s/%s observed=%0h expected=%0h t=%0t", phase, tag, obs, exp, $time);
    end
  endtask

  task automatic timeout(input string tag);
    n_chk++;
    n_err++;
    $display("FAIL %s/%s wait budget expired t=%0t", phase, tag, $time);
  endtask

  function automatic int mval(input int base);
    int v;
    v = 0;
    for (int i = ND - 1; i >= 0; i--) v = v * base + m_dig[i];
    return v;
  endfunction

  // Advance the model across one clock edge using the inputs present there.
  task automatic model_edge();
    int  idx, base, span, v;
    bit  blank, fall;
    if (!rst) begin
      for (int i = 0; i < ND; i++) m_dig[i] = 0;
      m_pre = 0; m_cyc = 0; m_prev_hex = 1'b0;
      e_seg = 7'h3F; e_sel = ND'(1); e_tick = 1'b0; e_wrap = 1'b0;
    end else begin
      // Outputs show the digit/index that were current before this edge.
      idx   = (m_cyc / REFC) % ND;
      e_sel = ND'(1) << idx;
      blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      if (idx > 0) begin
        blank = 1'b1;
        for (int j = idx; j < ND; j++) if (m_dig[j] != 0) blank = 1'b0;
      end
`endif
      e_seg  = blank ? 7'h00 : glyph[m_dig[idx]];
      m_cyc  = (m_cyc + 1) % (REFC * ND);
      e_tick = 1'b0;
      e_wrap = 1'b0;
      fall       = m_prev_hex && !hex_mode;
      m_prev_hex = hex_mode;
      if (clear) begin
        for (int i = 0; i < ND; i++) m_dig[i] = 0;
        m_pre = 0;
      end else begin
        bit due;
        due = 1'b0;
        if (en) begin
          if (m_pre == MAXC - 1) begin m_pre = 0; due = 1'b1; end
          else m_pre++;
        end
        if (fall) begin
          for (int i = 0; i < ND; i++) if (m_dig[i] > 9) m_dig[i] = 0;
        end else if (due) begin
          base = hex_mode ? 16 : 10;
          span = base ** ND;
          v    = mval(base);
          if (up) begin
            v = v + 1;
            if (v == span) begin v = 0; e_wrap = 1'b1; end
          end else begin
            if (v == 0) begin v = span - 1; e_wrap = 1'b1; end
            else v = v - 1;
          end
          for (int i = 0; i < ND; i++) begin
            m_dig[i] = v % base;
            v = v / base;
          end
          e_tick = 1'b1;
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    if (wrap === 1'b1) dut_wraps++;
    chk("tick", {31'd0, tick}, {31'd0, e_tick});
    chk("wrap", {31'd0, wrap}, {31'd0, e_wrap});
    chk("segments", {25'd0, segments}, {25'd0, e_seg});
    chk("digit_sel", {{(32-ND){1'b0}}, digit_sel}, {{(32-ND){1'b0}}, e_sel});
  endtask

  task automatic do_reset();
    rst = 1'b0; clear = 1'b0;
    repeat (2) cyc();
    rst = 1'b1;
  endtask

  initial begin
    int budget;
    glyph[0]  = 7'h3F; glyph[1]  = 7'h06; glyph[2]  = 7'h5B; glyph[3]  = 7'h4F;
    glyph[4]  = 7'h66; glyph[5]  = 7'h6D; glyph[6]  = 7'h7D; glyph[7]  = 7'h07;
    glyph[8]  = 7'h7F; glyph[9]  = 7'h6F; glyph[10] = 7'h77; glyph[11] = 7'h7C;
    glyph[12] = 7'h39; glyph[13] = 7'h5E; glyph[14] = 7'h79; glyph[15] = 7'h71;

    rst = 1'b0; en = 1'b0; up = 1'b1; hex_mode = 1'b0; clear = 1'b0;
    #2;

    // Reset state
    phase = "reset";
    do_reset();

    // Decimal up through 99 -> 00
    phase = "dec_up";
    en = 1'b1; up = 1'b1; hex_mode = 1'b0;
    dut_wraps = 0;
    repeat (400) cyc();
    chk("wrap_count", dut_wraps, 1);
    chk("count_after_wrap", mval(10), 0);

    // Hex down from 00 -> FF on the first tick
    phase = "hex_down";
    en = 1'b0;
    do_reset();
    en = 1'b1; up = 1'b0; hex_mode = 1'b1;
    dut_wraps = 0;
    repeat (12) cyc();
    chk("wrap_count", dut_wraps, 1);

    // Clear on the step edge at count 37
    phase = "clear_tick";
    en = 1'b0; hex_mode = 1'b0;
    do_reset();
    en = 1'b1; up = 1'b1;
    budget = 0;
    while (!(mval(10) == 37 && m_pre == MAXC - 1) && budget < 1000) begin
      cyc(); budget++;
    end
    if (budget >= 1000) timeout("reach_37");
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    chk("count_cleared", mval(10), 0);
    repeat (10) cyc();

    // Hex 1C then drop to decimal
    phase = "clamp";
    en = 1'b0; hex_mode = 1'b1;
    do_reset();
    en = 1'b1; up = 1'b1;
    budget = 0;
    while (mval(16) != 'h1C && budget < 1000) begin
      cyc(); budget++;
    end
    if (budget >= 1000) timeout("reach_1C");
    hex_mode = 1'b0;
    cyc();
    chk("clamped", mval(10), 10);
    repeat (12) cyc();

    // Mux alternation with count 05, frozen
    phase = "mux_blank";
    en = 1'b0;
    do_reset();
    en = 1'b1; up = 1'b1;
    budget = 0;
    while (mval(10) != 5 && budget < 200) begin
      cyc(); budget++;
    end
    if (budget >= 200) timeout("reach_05");
    en = 1'b0;
    repeat (12) cyc();

    // Randomised traffic
    phase = "random";
    for (int k = 0; k < 3000; k++) begin
      en    = ($urandom % 8) != 0;
      if (($urandom % 64) == 0)  up = ~up;
      if (($urandom % 96) == 0)  hex_mode = ~hex_mode;
      clear = ($urandom % 150) == 0;
      rst   = ($urandom % 700) != 0;
      cyc();
    end
    rst = 1'b1; clear = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
